// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with MEM/WB operand forwarding
// and single-cycle load-use bubble insertion, feeding the ALU directly.
module ex_operand_stage #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [width-1:0] RD1D,
    input  logic [width-1:0] RD2D,
    input  logic [width-1:0] ImmExtD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic [2:0]       ALUControlD,
    input  logic             ALUSrcD,
    input  logic             RegWriteD,
    input  logic             MemReadD,
    input  logic             ValidD,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [width-1:0] ALUResultM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    input  logic [width-1:0] ResultW,
    output logic [width-1:0] SrcAE,
    output logic [width-1:0] SrcBE,
    output logic [width-1:0] WriteDataE,
    output logic [2:0]       ALUControlE,
    output logic [4:0]       RdE,
    output logic             RegWriteE,
    output logic             MemReadE,
    output logic             ValidE,
    output logic             LoadUseStall
);
    logic [width-1:0] rd1_e, rd2_e, imm_e, fwd_a, fwd_b;
    logic [4:0]       rs1_e, rs2_e;
    logic             alu_src_e, bubble;

    assign LoadUseStall = MemReadE & ValidE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D))
                          & ~StallE & ~FlushE;
    assign bubble = FlushE | LoadUseStall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd1_e       <= '0;
            rd2_e       <= '0;
            imm_e       <= '0;
            rs1_e       <= '0;
            rs2_e       <= '0;
            RdE         <= '0;
            ALUControlE <= '0;
            alu_src_e   <= 1'b0;
            RegWriteE   <= 1'b0;
            MemReadE    <= 1'b0;
            ValidE      <= 1'b0;
        end else if (bubble) begin
            rd1_e       <= '0;
            rd2_e       <= '0;
            imm_e       <= '0;
            rs1_e       <= '0;
            rs2_e       <= '0;
            RdE         <= '0;
            ALUControlE <= '0;
            alu_src_e   <= 1'b0;
            RegWriteE   <= 1'b0;
            MemReadE    <= 1'b0;
            ValidE      <= 1'b0;
        end else if (!StallE) begin
            rd1_e       <= RD1D;
            rd2_e       <= RD2D;
            imm_e       <= ImmExtD;
            rs1_e       <= Rs1D;
            rs2_e       <= Rs2D;
            RdE         <= RdD;
            ALUControlE <= ALUControlD;
            alu_src_e   <= ALUSrcD;
            RegWriteE   <= RegWriteD & ValidD;
            MemReadE    <= MemReadD & ValidD;
            ValidE      <= ValidD;
        end
    end

    // MEM result is newer than WB, so it wins; x0 always reads the register value
    always_comb begin
        fwd_a = (RegWriteM && RdM != 5'd0 && RdM == rs1_e) ? ALUResultM :
                (RegWriteW && RdW != 5'd0 && RdW == rs1_e) ? ResultW : rd1_e;
        fwd_b = (RegWriteM && RdM != 5'd0 && RdM == rs2_e) ? ALUResultM :
                (RegWriteW && RdW != 5'd0 && RdW == rs2_e) ? ResultW : rd2_e;
    end

    assign SrcAE      = fwd_a;
    assign WriteDataE = fwd_b;
    assign SrcBE      = alu_src_e ? imm_e : fwd_b;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed scenarios plus randomized traffic checked
// against a per-instruction model of the E slot.
module tb_ex_operand_stage;
    logic        clk = 1'b0, reset_n = 1'b1;
    logic [31:0] RD1D = '0, RD2D = '0, ImmExtD = '0, ALUResultM = '0, ResultW = '0;
    logic [4:0]  Rs1D = '0, Rs2D = '0, RdD = '0, RdM = '0, RdW = '0;
    logic [2:0]  ALUControlD = '0;
    logic        ALUSrcD = 0, RegWriteD = 0, MemReadD = 0, ValidD = 0;
    logic        StallE = 0, FlushE = 0, RegWriteM = 0, RegWriteW = 0;
    logic [31:0] SrcAE, SrcBE, WriteDataE;
    logic [2:0]  ALUControlE;
    logic [4:0]  RdE;
    logic        RegWriteE, MemReadE, ValidE, LoadUseStall;
    int          total = 0, bad = 0;

    ex_operand_stage #(.width(32)) dut (
        .clk(clk), .reset_n(reset_n), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
        .RegWriteD(RegWriteD), .MemReadD(MemReadD), .ValidD(ValidD), .StallE(StallE),
        .FlushE(FlushE), .RdM(RdM), .RegWriteM(RegWriteM), .ALUResultM(ALUResultM),
        .RdW(RdW), .RegWriteW(RegWriteW), .ResultW(ResultW), .SrcAE(SrcAE), .SrcBE(SrcBE),
        .WriteDataE(WriteDataE), .ALUControlE(ALUControlE), .RdE(RdE), .RegWriteE(RegWriteE),
        .MemReadE(MemReadE), .ValidE(ValidE), .LoadUseStall(LoadUseStall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  alu;
        logic        src, rw, mr, v;
    } e_t;
    e_t m = '0;

    logic [107:0] act;
    assign act = {SrcAE, SrcBE, WriteDataE, ALUControlE, RdE, RegWriteE, MemReadE, ValidE, LoadUseStall};

    function automatic logic exp_lus();
        return m.mr && m.v && m.rd != 0 && (m.rd == Rs1D || m.rd == Rs2D) && !StallE && !FlushE;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
        if (RegWriteM && RdM != 0 && RdM == rs) return ALUResultM;
        if (RegWriteW && RdW != 0 && RdW == rs) return ResultW;
        return rf;
    endfunction

    function automatic logic [107:0] exp_out();
        logic [31:0] a, b;
        a = fwd(m.rs1, m.rd1);
        b = fwd(m.rs2, m.rd2);
        return {a, m.src ? m.imm : b, b, m.alu, m.rd, m.rw, m.mr, m.v, exp_lus()};
    endfunction

    function automatic e_t cap();
        e_t c;
        c = '{rd1: RD1D, rd2: RD2D, imm: ImmExtD, rs1: Rs1D, rs2: Rs2D, rd: RdD, alu: ALUControlD,
              src: ALUSrcD, rw: RegWriteD & ValidD, mr: MemReadD & ValidD, v: ValidD};
        return c;
    endfunction

    task automatic tick();
        e_t nx;
        nx = FlushE ? e_t'('0) : StallE ? m : exp_lus() ? e_t'('0) : cap();
        @(posedge clk);
        m = nx;
        #1;
    endtask

    task automatic drive_d(input logic [4:0] rs1, rs2, rd, input logic [31:0] d1, d2, imm,
                           input logic [2:0] alu, input logic src, rw, mr, v);
        Rs1D = rs1; Rs2D = rs2; RdD = rd; RD1D = d1; RD2D = d2; ImmExtD = imm;
        ALUControlD = alu; ALUSrcD = src; RegWriteD = rw; MemReadD = mr; ValidD = v;
    endtask

    task automatic mw_off();
        RegWriteM = 0; RegWriteW = 0; RdM = 0; RdW = 0; ALUResultM = 0; ResultW = 0;
    endtask

    task automatic test_reset();
        #2;
        RegWriteM = 1; RdM = 0; ALUResultM = 32'hDEAD;
        reset_n = 0;
        m = '0;
        #1;
        total++;
        if (act !== '0) begin bad++; $display("FAIL reset_async act=%h exp=0", act); end
        @(posedge clk); #1;
        total++;
        if (act !== exp_out()) begin bad++; $display("FAIL reset_held act=%h exp=%h", act, exp_out()); end
        reset_n = 1;
        mw_off();
    endtask

    task automatic test_mem_wb_priority();
        drive_d(5, 0, 1, 32'h11, 0, 0, 3'd0, 0, 1, 0, 1);
        tick();
        RdM = 5; RegWriteM = 1; ALUResultM = 32'h22;
        RdW = 5; RegWriteW = 1; ResultW = 32'h33;
        #1;
        total++;
        if (SrcAE !== 32'h22) begin bad++; $display("FAIL mem_priority SrcAE=%h exp=22", SrcAE); end
        RegWriteM = 0;
        #1;
        total++;
        if (SrcAE !== 32'h33) begin bad++; $display("FAIL wb_forward SrcAE=%h exp=33", SrcAE); end
        RdW = 6;
        #1;
        total++;
        if (SrcAE !== 32'h11) begin bad++; $display("FAIL no_forward SrcAE=%h exp=11", SrcAE); end
        mw_off();
    endtask

    task automatic test_imm_store();
        drive_d(1, 7, 2, 0, 32'h40, 32'hFFFF_FFFC, 3'd2, 1, 1, 0, 1);
        tick();
        RdW = 7; RegWriteW = 1; ResultW = 32'h99;
        #1;
        total++;
        if (SrcBE !== 32'hFFFF_FFFC) begin bad++; $display("FAIL imm_select SrcBE=%h exp=fffffffc", SrcBE); end
        total++;
        if (WriteDataE !== 32'h99) begin bad++; $display("FAIL store_fwd WriteDataE=%h exp=99", WriteDataE); end
        total++;
        if (ALUControlE !== 3'd2) begin bad++; $display("FAIL alu_ctrl ALUControlE=%h exp=2", ALUControlE); end
        mw_off();
    endtask

    task automatic test_load_use();
        drive_d(0, 0, 3, 0, 0, 0, 3'd0, 1, 1, 1, 1);
        tick();
        drive_d(3, 0, 4, 32'h5, 0, 0, 3'd1, 0, 1, 0, 1);
        #1;
        total++;
        if (LoadUseStall !== 1'b1) begin bad++; $display("FAIL lus_detect got=%b exp=1", LoadUseStall); end
        tick();
        total++;
        if ({ValidE, RegWriteE, LoadUseStall} !== 3'b000)
            begin bad++; $display("FAIL lus_bubble v/rw/lus=%b exp=000", {ValidE, RegWriteE, LoadUseStall}); end
        tick();
        total++;
        if ({ValidE, RdE, ALUControlE} !== {1'b1, 5'd4, 3'd1})
            begin bad++; $display("FAIL lus_capture v=%b rd=%0d alu=%0d exp v=1 rd=4 alu=1", ValidE, RdE, ALUControlE); end
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        drive_d(0, 0, 3, 0, 0, 0, 3'd0, 0, 1, 1, 1);
        tick();
        drive_d(3, 0, 4, 0, 0, 0, 3'd0, 0, 1, 1, 1);
        for (int i = 0; i < 2; i++) begin #1; stalls += int'(LoadUseStall); tick(); end
        total++;
        if ({MemReadE, RdE} !== {1'b1, 5'd4}) begin bad++; $display("FAIL b2b_load2 mr=%b rd=%0d exp mr=1 rd=4", MemReadE, RdE); end
        drive_d(0, 4, 5, 0, 32'h7, 0, 3'd0, 0, 1, 0, 1);
        for (int i = 0; i < 2; i++) begin #1; stalls += int'(LoadUseStall); tick(); end
        total++;
        if ({ValidE, RdE} !== {1'b1, 5'd5}) begin bad++; $display("FAIL b2b_dep v=%b rd=%0d exp v=1 rd=5", ValidE, RdE); end
        total++;
        if (stalls != 2) begin bad++; $display("FAIL b2b_bubbles got=%0d exp=2", stalls); end
    endtask

    task automatic test_stall_flush();
        drive_d(2, 3, 9, 32'hA, 32'hB, 0, 3'd4, 0, 1, 0, 1);
        tick();
        StallE = 1;
        for (int i = 0; i < 3; i++) begin
            drive_d(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 5'($urandom_range(10, 31)),
                    $urandom, $urandom, $urandom, 3'($urandom), 0, 1, 1, 1);
            tick();
            total++;
            if ({ValidE, RdE, SrcAE, ALUControlE} !== {1'b1, 5'd9, 32'hA, 3'd4})
                begin bad++; $display("FAIL stall_hold v=%b rd=%0d a=%h alu=%0d", ValidE, RdE, SrcAE, ALUControlE); end
        end
        FlushE = 1;
        tick();
        total++;
        if ({ValidE, RdE, RegWriteE, MemReadE} !== 8'b0)
            begin bad++; $display("FAIL flush_wins v=%b rd=%0d rw=%b mr=%b exp all 0", ValidE, RdE, RegWriteE, MemReadE); end
        StallE = 0; FlushE = 0;
    endtask

    task automatic test_x0();
        drive_d(0, 0, 1, 32'h77, 0, 0, 3'd0, 0, 1, 0, 1);
        tick();
        RdM = 0; RegWriteM = 1; ALUResultM = 32'h5; RdW = 0; RegWriteW = 1; ResultW = 32'h6;
        #1;
        total++;
        if (SrcAE !== 32'h77) begin bad++; $display("FAIL x0_no_fwd SrcAE=%h exp=77", SrcAE); end
        mw_off();
    endtask

    task automatic test_reset_mid_stall();
        drive_d(1, 2, 8, 32'h3, 32'h4, 0, 3'd5, 0, 1, 0, 1);
        tick();
        StallE = 1;
        #2;
        reset_n = 0; RegWriteM = 1; RdM = 0;
        m = '0;
        #1;
        total++;
        if (act !== '0) begin bad++; $display("FAIL reset_mid_stall act=%h exp=0", act); end
        reset_n = 1; StallE = 0;
        mw_off();
        drive_d(1, 2, 6, 32'h3, 32'h4, 0, 3'd1, 0, 1, 0, 1);
        tick();
        total++;
        if ({ValidE, RdE} !== {1'b1, 5'd6}) begin bad++; $display("FAIL post_reset_capture v=%b rd=%0d exp v=1 rd=6", ValidE, RdE); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_d(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    $urandom, $urandom, $urandom, 3'($urandom), 1'($urandom),
                    1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 4) != 0);
            StallE = $urandom_range(0, 7) == 0;
            FlushE = $urandom_range(0, 15) == 0;
            RdM = 5'($urandom_range(0, 7)); RegWriteM = 1'($urandom); ALUResultM = $urandom;
            RdW = 5'($urandom_range(0, 7)); RegWriteW = 1'($urandom); ResultW = $urandom;
            #1;
            total++;
            if (act !== exp_out()) begin bad++; $display("FAIL random_%0d act=%h exp=%h", i, act, exp_out()); end
            tick();
        end
        StallE = 0; FlushE = 0;
        mw_off();
    endtask

    initial begin
        test_reset();
        test_mem_wb_priority();
        test_imm_store();
        test_load_use();
        test_back_to_back();
        test_stall_flush();
        test_x0();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
